unpadding_stream: RTL
=====================

UNPADDING_STREAM -- requirements
Module: unpadding_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 16: pixel width in bits.
REQ-002 Parameter D, default 1: channel count.
REQ-003 Parameter H, default 10: unpadded image height.
REQ-004 Parameter W, default 10: unpadded image width.
REQ-005 Parameter P, default 2: border width on each side; legal range 0..8.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 in_valid  input  1  in_data holds a padded-frame pixel.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 in_data  input  DATA_WIDTH  padded pixel; raster order is column fastest, then row, then channel.
REQ-011 out_valid  output  1  out_data holds an interior pixel.
REQ-012 out_ready  input  1  downstream accepts out_data.
REQ-013 out_data  output  DATA_WIDTH  interior pixel, in the same raster order.
REQ-014 out_last  output  1  marks the final interior pixel of the final channel of a frame.
REQ-015 border_err  output  1  sticky flag for a non-zero border pixel; present only with the macro in REQ-033.

Function
REQ-016 An input pixel is accepted on a cycle where in_valid and in_ready are both 1.
REQ-017 Input counters: col counts 0..W+2P-1, row counts 0..H+2P-1, ch counts 0..D-1.
- Each counter is $clog2(max+1) bits wide, minimum 1 bit.
- col advances on every accepted pixel; row and ch advance on wrap of the next-faster counter.
- All three wrap to 0 after the final pixel of a frame.
REQ-018 A pixel is interior iff P<=row<P+H and P<=col<P+W; every other pixel is border.
REQ-019 Border pixels are accepted and discarded and never appear on the output.
REQ-020 The output uses a single-entry register.
- in_ready = !out_valid || out_ready (combinational).
- An accepted interior pixel loads out_data and sets out_valid on the next edge: latency 1 cycle.
REQ-021 out_valid clears on an edge where out_valid && out_ready and no new interior pixel is loaded.
- If a new interior pixel loads on that same edge, out_valid stays 1.
REQ-022 While out_valid && !out_ready: out_data and out_last hold stable, and in_ready = 0.
REQ-023 out_last = 1 iff the registered pixel had ch=D-1, row=P+H-1 and col=P+W-1.
- out_last is loaded together with out_data.
REQ-024 With P=0 every pixel is interior: output equals input delayed one cycle, subject to handshake.
REQ-025 Each frame emits exactly D*H*W outputs for D*(H+2P)*(W+2P) accepted inputs.
REQ-026 Back-to-back frames need no idle cycle between them.

Reset
REQ-027 While rst=1, regardless of clk: col, row and ch = 0.
REQ-028 While rst=1: out_valid = 0, out_data = 0, out_last = 0, border_err = 0.
REQ-029 A reset mid-frame discards the partial frame and any pending output.
- The first accepted pixel after reset is treated as row 0, col 0, ch 0.
REQ-030 in_ready = 1 while rst=1, because out_valid = 0.
- Pixels presented while rst=1 are not counted.
REQ-031 Reset deassertion is the synchronizer's responsibility, outside this block.

Configuration
REQ-032 Exactly one optional feature: border checking.
REQ-033 With UNPADDING_BORDER_CHECK_EN defined:
- border_err is present.
- border_err is set on the edge after any accepted border pixel with in_data != 0.
- border_err stays set until rst.
REQ-034 Without the macro: the border_err port and its logic are absent, and border data is ignored.

Verification
REQ-035 Nominal frame:
- Stimulus: defaults, out_ready=1, 196-pixel frame; border = 16'h0000, interior = 16'h4444.
- Response: exactly 100 outputs, all 16'h4444; out_last only on the 100th; border_err=0.
REQ-036 Backpressure:
- Stimulus: same frame; out_ready toggles 1,0,0,1 repeating; interior pixels numbered 1..100.
- Response: outputs in order 1..100, none lost or duplicated; out_data stable while stalled; in_ready=0 while stalled.
REQ-037 Reset mid-frame:
- Stimulus: assert rst asynchronously after pixel 57, then send a fresh full frame.
- Response: out_valid=0 immediately; exactly 100 outputs from the new frame; out_last on the 100th.
REQ-038 Parameter corner (P=0, H=2, W=3, D=2):
- Stimulus: inputs 1..12.
- Response: outputs 1..12 at 1-cycle latency; out_last only with 12.
REQ-039 Border check (macro defined):
- Stimulus: border pixel at row 0, col 5 = 16'h0001.
- Response: border_err=1 from the next edge onward; cleared only by rst; interior output unaffected.
REQ-040 Back-to-back frames:
- Stimulus: two frames with no gap, interior 16'h1111 then 16'h2222.
- Response: 200 outputs; out_last on outputs 100 and 200; no output while border pixels are consumed.

Source files
------------

// File: rtl/unpadding_stream.sv
// -----------------------------------------------------------------------------
// unpadding_stream
//
// Strips a P-pixel border from every side of a padded image stream. Pixels
// arrive in raster order (column fastest, then row, then channel) on a
// valid/ready input. Interior pixels pass through a single-entry output
// register. Border pixels are accepted and dropped.
//
// Parameters:
//   DATA_WIDTH  pixel width in bits
//   D           channel count
//   H, W        unpadded image height / width
//   P           border width on each side (0..8)
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   in_valid    in_data holds a padded-frame pixel
//   in_ready    block accepts in_data this cycle
//   in_data     padded pixel
//   out_valid   out_data holds an interior pixel
//   out_ready   downstream accepts out_data
//   out_data    interior pixel
//   out_last    final interior pixel of the final channel of a frame
//   border_err  sticky: a non-zero border pixel was accepted
//               (only when UNPADDING_BORDER_CHECK_EN is defined)
//
// Optional feature macro: UNPADDING_BORDER_CHECK_EN
// -----------------------------------------------------------------------------
module unpadding_stream #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned D          = 1,
    parameter int unsigned H          = 10,
    parameter int unsigned W          = 10,
    parameter int unsigned P          = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
`ifdef UNPADDING_BORDER_CHECK_EN
    ,
    output logic                  border_err
`endif
);

    localparam int unsigned WP  = W + 2 * P;
    localparam int unsigned HP  = H + 2 * P;
    localparam int unsigned CW  = (WP > 1) ? $clog2(WP) : 1;
    localparam int unsigned RW  = (HP > 1) ? $clog2(HP) : 1;
    localparam int unsigned CHW = (D > 1) ? $clog2(D) : 1;

    localparam logic [CW-1:0]  COL_END   = CW'(WP - 1);
    localparam logic [CW-1:0]  COL_FIRST = CW'(P);
    localparam logic [CW-1:0]  COL_LAST  = CW'(P + W - 1);
    localparam logic [RW-1:0]  ROW_END   = RW'(HP - 1);
    localparam logic [RW-1:0]  ROW_FIRST = RW'(P);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(P + H - 1);
    localparam logic [CHW-1:0] CH_END    = CHW'(D - 1);

    if (P > 8) begin : g_bad_p
        $error("unpadding_stream: P must be in 0..8");
    end

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CHW-1:0]        ch_q, ch_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;

    logic accept;
    logic interior;
    logic frame_last;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Upper bounds use the last interior index so they fit the counter width
    // even when P = 0.
    assign interior = (row_q >= ROW_FIRST) && (row_q <= ROW_LAST) &&
                      (col_q >= COL_FIRST) && (col_q <= COL_LAST);

    assign frame_last = (ch_q == CH_END) && (row_q == ROW_LAST) && (col_q == COL_LAST);

    // Position counters: col fastest, row on col wrap, ch on row wrap.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        ch_d  = ch_q;
        if (accept) begin
            if (col_q == COL_END) begin
                col_d = '0;
                if (row_q == ROW_END) begin
                    row_d = '0;
                    if (ch_q == CH_END) begin
                        ch_d = '0;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Output register: a load takes priority over a drain so a pixel handed
    // off and a new one loaded on the same edge keeps out_valid high.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (accept && interior) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_last_d  = frame_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

`ifdef UNPADDING_BORDER_CHECK_EN
    logic border_err_q, border_err_d;

    assign border_err_d = border_err_q || (accept && !interior && (|in_data));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            border_err_q <= 1'b0;
        end else begin
            border_err_q <= border_err_d;
        end
    end

    assign border_err = border_err_q;
`endif

endmodule
